sobel_calc: RTL and testbench

- Computes the 3x3 Sobel gradient magnitude for a streamed 8-bit grayscale image.
- Upstream, the line-buffer stage delivers one column of three vertically adjacent pixels per pi_flag pulse.
- Builds the sliding 3x3 window, computes |Gx|+|Gy|, binarizes against a threshold, and emits one pixel per complete window.
- Downstream, the frame RAM writer stores the emitted pixels for VGA readout.

---
 rtl/sobel_calc_if.sv | 20 ++
 rtl/sobel_calc.sv | 142 ++++++++++++++
 tb/tb_sobel_calc.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_calc_if.sv
// Stream interface for sobel_calc: column-triple input strobe and binarized/gray pixel output.
interface sobel_calc_if;
    logic       pi_flag;
    logic [7:0] line0;
    logic [7:0] line1;
    logic [7:0] line2;
    logic       po_flag;
    logic [7:0] po_data;
    logic       po_done;

    modport master (
        output pi_flag, line0, line1, line2,
        input  po_flag, po_data, po_done
    );

    modport slave (
        input  pi_flag, line0, line1, line2,
        output po_flag, po_data, po_done
    );
endinterface

// File: rtl/sobel_calc.sv
// 3x3 Sobel |Gx|+|Gy| over a streamed column-triple image, three-stage pipeline.
// Build option SOBEL_GRAY_OUT_EN: output the saturated magnitude instead of a thresholded pixel.
module sobel_calc #(
    parameter int COL_NUM = 100,
    parameter int ROW_NUM = 100,
    parameter int THRESH  = 120
) (
    input  logic         sclk,
    input  logic         rst,
    sobel_calc_if.slave  bus
);
    localparam int COL_W = $clog2(COL_NUM);
    localparam int ROW_W = $clog2(ROW_NUM);

    logic [COL_W-1:0]   r_col_cnt;
    logic [ROW_W-1:0]   r_row_cnt;
    logic [7:0]         r_p11, r_p12, r_p13;
    logic [7:0]         r_p21, r_p22, r_p23;
    logic [7:0]         r_p31, r_p32, r_p33;
    logic               r_v1, r_d1, r_v2, r_d2;
    logic signed [10:0] r_gx, r_gy;
    logic               r_po_flag, r_po_done;
    logic [7:0]         r_po_data;

    logic               w_win_valid, w_col_last, w_row_last;
    logic [9:0]         w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic signed [10:0] w_gx, w_gy;
    logic [9:0]         w_abs_gx, w_abs_gy;
    logic [10:0]        w_mag;
    logic [7:0]         w_pix;

    function automatic logic [9:0] abs11(input logic signed [10:0] v);
        logic signed [10:0] n;
        n = -v;
        if (v < 11'sd0) begin
            return n[9:0];
        end else begin
            return v[9:0];
        end
    endfunction

    // Column position decode and kernel arithmetic on the current window
    always_comb begin
        w_col_last  = (r_col_cnt == COL_W'(COL_NUM - 1));
        w_row_last  = (r_row_cnt == ROW_W'(ROW_NUM - 3));
        w_win_valid = bus.pi_flag && (r_col_cnt >= COL_W'(2));
        w_gx_pos    = {2'b00, r_p13} + {1'b0, r_p23, 1'b0} + {2'b00, r_p33};
        w_gx_neg    = {2'b00, r_p11} + {1'b0, r_p21, 1'b0} + {2'b00, r_p31};
        w_gy_pos    = {2'b00, r_p31} + {1'b0, r_p32, 1'b0} + {2'b00, r_p33};
        w_gy_neg    = {2'b00, r_p11} + {1'b0, r_p12, 1'b0} + {2'b00, r_p13};
        w_gx        = $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
        w_gy        = $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
    end

    // Magnitude and output pixel mapping from the registered gradients
    always_comb begin
        w_abs_gx = abs11(r_gx);
        w_abs_gy = abs11(r_gy);
        w_mag    = {1'b0, w_abs_gx} + {1'b0, w_abs_gy};
`ifdef SOBEL_GRAY_OUT_EN
        if (w_mag > 11'd255) begin
            w_pix = 8'hFF;
        end else begin
            w_pix = w_mag[7:0];
        end
`else
        if (w_mag >= 11'(THRESH)) begin
            w_pix = 8'hFF;
        end else begin
            w_pix = 8'h00;
        end
`endif
    end

    // Column/row position counters; row wraps after ROW_NUM-2 input rows
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (bus.pi_flag) begin
            if (w_col_last) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_row_last ? '0 : r_row_cnt + ROW_W'(1);
            end else begin
                r_col_cnt <= r_col_cnt + COL_W'(1);
            end
        end
    end

    // Stage 1: window shift (not cleared at row wrap; cols 0/1 never form a valid window)
    always_ff @(posedge sclk) begin
        if (rst) begin
            {r_p11, r_p12, r_p13} <= 24'd0;
            {r_p21, r_p22, r_p23} <= 24'd0;
            {r_p31, r_p32, r_p33} <= 24'd0;
            r_v1 <= 1'b0;
            r_d1 <= 1'b0;
        end else begin
            r_v1 <= w_win_valid;
            r_d1 <= w_win_valid && w_col_last && w_row_last;
            if (bus.pi_flag) begin
                {r_p11, r_p12, r_p13} <= {r_p12, r_p13, bus.line0};
                {r_p21, r_p22, r_p23} <= {r_p22, r_p23, bus.line1};
                {r_p31, r_p32, r_p33} <= {r_p32, r_p33, bus.line2};
            end
        end
    end

    // Stage 2: registered gradients
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_gx <= 11'sd0;
            r_gy <= 11'sd0;
            r_v2 <= 1'b0;
            r_d2 <= 1'b0;
        end else begin
            r_gx <= w_gx;
            r_gy <= w_gy;
            r_v2 <= r_v1;
            r_d2 <= r_d1;
        end
    end

    // Stage 3: output registers; data holds between strobes
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_po_flag <= 1'b0;
            r_po_done <= 1'b0;
            r_po_data <= 8'h00;
        end else begin
            r_po_flag <= r_v2;
            r_po_done <= r_d2;
            if (r_v2) begin
                r_po_data <= w_pix;
            end
        end
    end

    assign bus.po_flag = r_po_flag;
    assign bus.po_done = r_po_done;
    assign bus.po_data = r_po_data;
endmodule

// File: tb/tb_sobel_calc.sv
// Scoreboard bench for sobel_calc: a frame-level Sobel model predicts every output pixel.
module tb_sobel_calc;
    localparam int COL_NUM = 100;
    localparam int ROW_NUM = 100;
    localparam int THRESH  = 120;
    localparam int LAT     = 3;

    logic sclk = 1'b0;
    logic rst;
    sobel_calc_if bus ();

    sobel_calc #(.COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM), .THRESH(THRESH)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [7:0] d;
        logic       done;
        longint     cyc;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    logic   chk_idle = 1'b0;

    int h0[COL_NUM];
    int h1[COL_NUM];
    int h2[COL_NUM];
    int m_col = 0;
    int m_row = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    // Monitor: pop and compare on each output strobe; also flag overdue and unsolicited outputs
    always @(negedge sclk) begin
        exp_t e;
        if (chk_idle) begin
            n_tests++;
            if (bus.po_flag !== 1'b0 || bus.po_data !== 8'h00 || bus.po_done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle: got flag=%b data=%02h done=%b expected 0/00/0",
                         bus.po_flag, bus.po_data, bus.po_done);
            end
        end
        if (bus.po_flag === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL extra_out: got po_data=%02h at cycle %0d expected no output",
                         bus.po_data, cyc);
            end else begin
                e = sb.pop_front();
                n_tests += 3;
                if (bus.po_data !== e.d) begin
                    n_fail++;
                    $display("FAIL data: got %02h expected %02h (cycle %0d)", bus.po_data, e.d, cyc);
                end
                if (bus.po_done !== e.done) begin
                    n_fail++;
                    $display("FAIL done: got %b expected %b (cycle %0d)", bus.po_done, e.done, cyc);
                end
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL latency: got output at cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end else begin
            if (bus.po_done === 1'b1) begin
                n_tests++; n_fail++;
                $display("FAIL done_no_flag: got po_done=1 with po_flag=0 expected po_done=0");
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missing_out: got no po_flag expected data %02h at cycle %0d",
                         e.d, e.cyc);
            end
        end
    end

    // Reference: Sobel over the three most recent columns of the current row
    task automatic model_issue(input int a, input int b, input int c);
        int gx, gy, mag, px, k;
        exp_t e;
        h0[m_col] = a; h1[m_col] = b; h2[m_col] = c;
        if (m_col >= 2) begin
            k  = m_col;
            gx = (h0[k] + 2 * h1[k] + h2[k]) - (h0[k-2] + 2 * h1[k-2] + h2[k-2]);
            gy = (h2[k-2] + 2 * h2[k-1] + h2[k]) - (h0[k-2] + 2 * h0[k-1] + h0[k]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_GRAY_OUT_EN
            px = (mag > 255) ? 255 : mag;
`else
            px = (mag >= THRESH) ? 255 : 0;
`endif
            e.d    = 8'(px);
            e.done = (m_col == COL_NUM - 1) && (m_row == ROW_NUM - 3);
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        if (m_col == COL_NUM - 1) begin
            m_col = 0;
            m_row = (m_row == ROW_NUM - 3) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gap);
        @(negedge sclk); #1;
        bus.pi_flag = 1'b1;
        bus.line0 = a; bus.line1 = b; bus.line2 = c;
        model_issue(int'(a), int'(b), int'(c));
        if (gap > 0) begin
            @(negedge sclk); #1;
            bus.pi_flag = 1'b0;
            repeat (gap - 1) @(negedge sclk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge sclk); #1;
        bus.pi_flag = 1'b0;
        repeat (n - 1) @(negedge sclk);
    endtask

    task automatic do_reset(input logic with_flag);
        @(negedge sclk); #1;
        rst = 1'b1;
        bus.pi_flag = with_flag;
        bus.line0 = 8'($urandom_range(0, 255));
        sb.delete();
        m_col = 0; m_row = 0;
        chk_idle = 1'b1;
        @(negedge sclk); #1;
        rst = 1'b0;
        bus.pi_flag = 1'b0;
        repeat (3) @(negedge sclk);
        #1 chk_idle = 1'b0;
    endtask

    task automatic drain();
        int t;
        idle(1);
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge sclk);
            t++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain: got %0d outputs still pending expected 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    task automatic send_frame(input int max_gap, input logic uniform);
        logic [7:0] a, b, c;
        for (int i = 0; i < COL_NUM * (ROW_NUM - 2); i++) begin
            if (uniform) begin
                a = 8'd80; b = 8'd80; c = 8'd80;
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                c = 8'($urandom_range(0, 255));
            end
            send(a, b, c, int'($urandom_range(0, max_gap)));
        end
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1;
        bus.pi_flag = 1'b0;
        bus.line0 = 8'h00; bus.line1 = 8'h00; bus.line2 = 8'h00;
        do_reset(1'b0);

        // Isolated window with gaps: outputs only for the third column
        send(8'd0, 8'd0, 8'd0, 3);
        send(8'd0, 8'd0, 8'd0, 4);
        send(8'd30, 8'd30, 8'd30, 5);
        drain();

        // Threshold boundary: 30 -> mag 120, 29 -> mag 116
        do_reset(1'b0);
        send(8'd0, 8'd0, 8'd0, 0);
        send(8'd0, 8'd0, 8'd0, 0);
        send(8'd29, 8'd29, 8'd29, 0);
        drain();

        // Vertical edge across one row
        do_reset(1'b0);
        for (int c = 0; c < COL_NUM; c++) begin
            v = (c >= 50) ? 8'd255 : 8'd0;
            send(v, v, v, 0);
        end
        drain();

        // Uniform frame back-to-back, then a random frame with random gaps
        do_reset(1'b0);
        send_frame(0, 1'b1);
        drain();
        send_frame(2, 1'b0);
        drain();

        // Reset mid-frame at row 5 col 40 with pipeline full and pi_flag high, then a full frame
        for (int i = 0; i < 5 * COL_NUM + 40; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        end
        do_reset(1'b1);
        send_frame(0, 1'b0);
        drain();

        repeat (5) @(negedge sclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
